class_vec_seq: RTL and testbench

Sequencer that drives the address inputs of the class hypervector generator (`class_vec_gen`). It streams the frames of one class, or of every class, to a downstream consumer over a valid/ready handshake. It sits between the training/inference control logic, which issues class requests, and the similarity/update datapath, which consumes 64-bit frames.

---
 rtl/class_seq_pkg.sv | 16 +
 rtl/class_seq_cnt.sv | 49 ++++
 rtl/class_vec_seq.sv | 132 +++++++++++++
 tb/tb_class_vec_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/class_seq_pkg.sv
// Shared defaults and FSM state encoding for the class vector sequencer.
package class_seq_pkg;

    localparam int NUM_CLASSES_D      = 8;
    localparam int FRAMES_PER_CLASS_D = 3;
    localparam int FRAME_W_D          = 64;
    localparam int CLASS_W_D          = 3;
    localparam int IDX_W_D            = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/class_seq_cnt.sv
// Class/frame-index counter: loads a start class, steps through frames and,
// in sweep mode, carries into the next class. last flags the final frame.
module class_seq_cnt
    import class_seq_pkg::*;
#(
    parameter int NUM_CLASSES      = NUM_CLASSES_D,
    parameter int FRAMES_PER_CLASS = FRAMES_PER_CLASS_D,
    parameter int CLASS_W          = CLASS_W_D,
    parameter int IDX_W            = IDX_W_D
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [CLASS_W-1:0] load_class,
    input  logic               load_sweep,
    input  logic               advance,
    output logic [CLASS_W-1:0] cls,
    output logic [IDX_W-1:0]   idx,
    output logic               last
);

    localparam logic [IDX_W-1:0]   IDX_MAX = IDX_W'(FRAMES_PER_CLASS - 1);
    localparam logic [CLASS_W-1:0] CLS_MAX = CLASS_W'(NUM_CLASSES - 1);

    logic sweep_q;

    // Counter only moves on load/advance so the generator address holds in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls     <= '0;
            idx     <= '0;
            sweep_q <= 1'b0;
        end else if (load) begin
            cls     <= load_class;
            idx     <= '0;
            sweep_q <= load_sweep;
        end else if (advance) begin
            if (idx == IDX_MAX) begin
                idx <= '0;
                if (sweep_q) cls <= cls + 1'b1;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign last = (idx == IDX_MAX) && (!sweep_q || (cls == CLS_MAX));

endmodule

// File: rtl/class_vec_seq.sv
// Class vector sequencer: addresses class_vec_gen and streams registered
// frames of one class (or all classes) over a valid/ready handshake.
// Optional macro CLASS_SEQ_SWEEP_EN adds the req_all port (all-class sweep).
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// FETCH | generator addressed, frame captured at end of cycle
// HOLD  | frame presented on out_*, waiting for out_ready
module class_vec_seq
    import class_seq_pkg::*;
#(
    parameter int NUM_CLASSES      = NUM_CLASSES_D,
    parameter int FRAMES_PER_CLASS = FRAMES_PER_CLASS_D,
    parameter int FRAME_W          = FRAME_W_D,
    parameter int CLASS_W          = CLASS_W_D,
    parameter int IDX_W            = IDX_W_D
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [CLASS_W-1:0] req_class,
`ifdef CLASS_SEQ_SWEEP_EN
    input  logic               req_all,
`endif
    input  logic               abort,
    output logic [CLASS_W-1:0] gen_frame_id,
    output logic [IDX_W-1:0]   gen_frame_index,
    input  logic [FRAME_W-1:0] gen_vec,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FRAME_W-1:0] out_data,
    output logic [CLASS_W-1:0] out_class,
    output logic [IDX_W-1:0]   out_frame,
    output logic               out_last,
    output logic               busy,
    output logic               err_bad_class
);

    seq_state_t state, state_nxt;
    logic       sweep_req, bad_class, start, advance, err_nxt, cnt_last;

`ifdef CLASS_SEQ_SWEEP_EN
    assign sweep_req = req_all;
`else
    assign sweep_req = 1'b0;
`endif

    // A sweep request ignores req_class entirely, range check included.
    assign bad_class = !sweep_req && (32'(req_class) >= NUM_CLASSES);

    class_seq_cnt #(
        .NUM_CLASSES     (NUM_CLASSES),
        .FRAMES_PER_CLASS(FRAMES_PER_CLASS),
        .CLASS_W         (CLASS_W),
        .IDX_W           (IDX_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (start),
        .load_class(sweep_req ? '0 : req_class),
        .load_sweep(sweep_req),
        .advance   (advance),
        .cls       (gen_frame_id),
        .idx       (gen_frame_index),
        .last      (cnt_last)
    );

    // Next-state logic; abort overrides every transition out of FETCH/HOLD.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        advance   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && !abort) begin
                    if (bad_class) begin
                        err_nxt = 1'b1;
                    end else begin
                        start     = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_FETCH: state_nxt = abort ? ST_IDLE : ST_HOLD;
            ST_HOLD: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (out_ready) begin
                    if (out_last) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Output frame capture at the end of FETCH; held untouched through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data      <= '0;
            out_class     <= '0;
            out_frame     <= '0;
            out_last      <= 1'b0;
            err_bad_class <= 1'b0;
        end else begin
            err_bad_class <= err_nxt;
            if (state == ST_FETCH && !abort) begin
                out_data  <= gen_vec;
                out_class <= gen_frame_id;
                out_frame <= gen_frame_index;
                out_last  <= cnt_last;
            end
        end
    end

    assign out_valid = (state == ST_HOLD);
    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_class_vec_seq.sv
// Self-checking bench for class_vec_seq against a frame-list reference model.
module tb_class_vec_seq;

    localparam int NC  = 8;
    localparam int FPC = 3;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  cls;
        logic [1:0]  frm;
        logic        last;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, abort, out_valid, out_ready, out_last, busy, err_bad_class;
    logic [2:0]  req_class, gen_frame_id, out_class;
    logic [1:0]  gen_frame_index, out_frame;
    logic [63:0] gen_vec, out_data;
`ifdef CLASS_SEQ_SWEEP_EN
    logic        req_all;
    logic        s_req_all;
`endif

    logic        s_req_valid, s_req_ready, s_abort, s_out_valid, s_out_ready, s_out_last, s_busy, s_err;
    logic [2:0]  s_req_class, s_gen_frame_id, s_out_class;
    logic [1:0]  s_gen_frame_index, s_out_frame;
    logic [63:0] s_gen_vec, s_out_data;

    logic [63:0] gen_mem [0:7][0:3];
    frame_t      exp_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign gen_vec   = gen_mem[gen_frame_id][gen_frame_index];
    assign s_gen_vec = gen_mem[s_gen_frame_id][s_gen_frame_index];

    class_vec_seq dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_class(req_class),
`ifdef CLASS_SEQ_SWEEP_EN
        .req_all(req_all),
`endif
        .abort(abort), .gen_frame_id(gen_frame_id), .gen_frame_index(gen_frame_index),
        .gen_vec(gen_vec), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_class(out_class), .out_frame(out_frame),
        .out_last(out_last), .busy(busy), .err_bad_class(err_bad_class)
    );

    class_vec_seq #(.NUM_CLASSES(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_class(s_req_class),
`ifdef CLASS_SEQ_SWEEP_EN
        .req_all(s_req_all),
`endif
        .abort(s_abort), .gen_frame_id(s_gen_frame_id), .gen_frame_index(s_gen_frame_index),
        .gen_vec(s_gen_vec), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_class(s_out_class), .out_frame(s_out_frame),
        .out_last(s_out_last), .busy(s_busy), .err_bad_class(s_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and consume the whole sequence.
    // mode 0: out_ready always 1; mode 1: 10-cycle stall on the first frame; mode 2: random.
    task automatic do_seq(input logic [2:0] c, input bit all, input int mode);
        int          cycles;
        int          stall_left;
        bit          held;
        frame_t      f;
        logic [63:0] hd;
        logic [2:0]  hc;
        logic [1:0]  hf;
        int          ncls;

        exp_q.delete();
        ncls = all ? NC : 1;
        for (int k = 0; k < ncls; k++) begin
            for (int i = 0; i < FPC; i++) begin
                f.cls  = all ? 3'(k) : c;
                f.frm  = 2'(i);
                f.data = gen_mem[f.cls][f.frm];
                f.last = (k == ncls - 1) && (i == FPC - 1);
                exp_q.push_back(f);
            end
        end

        req_valid = 1'b1;
        req_class = c;
`ifdef CLASS_SEQ_SWEEP_EN
        req_all = all;
`endif
        step();
        req_valid = 1'b0;
`ifdef CLASS_SEQ_SWEEP_EN
        req_all = 1'b0;
`endif
        check("accept_busy", 64'(busy), 64'(1));

        cycles     = 0;
        stall_left = (mode == 1) ? 10 : 0;
        held       = 1'b0;
        hd = '0; hc = '0; hf = '0;
        while (exp_q.size() > 0 && cycles < 400) begin
            if (mode == 1)      out_ready = !(out_valid && stall_left > 0);
            else if (mode == 2) out_ready = 1'($urandom_range(0, 1));
            else                out_ready = 1'b1;
            if (out_valid) begin
                if (held) begin
                    check("hold_data",  out_data, hd);
                    check("hold_class", 64'(out_class), 64'(hc));
                    check("hold_frame", 64'(out_frame), 64'(hf));
                end
                if (out_ready) begin
                    f = exp_q.pop_front();
                    check("frame_data",  out_data, f.data);
                    check("frame_class", 64'(out_class), 64'(f.cls));
                    check("frame_index", 64'(out_frame), 64'(f.frm));
                    check("frame_last",  64'(out_last), 64'(f.last));
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd = out_data; hc = out_class; hf = out_frame;
                    if (mode == 1) stall_left--;
                end
            end
            step();
            cycles++;
        end
        out_ready = 1'b1;
        check("seq_remaining", 64'(exp_q.size()), 64'(0));
        if (mode == 0) check("seq_cycles", 64'(cycles), 64'(2 * ncls * FPC));
        check("end_req_ready", 64'(req_ready), 64'(1));
        check("end_busy",      64'(busy), 64'(0));
        check("end_valid",     64'(out_valid), 64'(0));
    endtask

    initial begin
        bit found;
        int seen;

        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 4; b++)
                gen_mem[a][b] = {$urandom, $urandom};

        rst_n = 1'b0;
        req_valid = 1'b0; req_class = '0; abort = 1'b0; out_ready = 1'b1;
        s_req_valid = 1'b0; s_req_class = '0; s_abort = 1'b0; s_out_ready = 1'b1;
`ifdef CLASS_SEQ_SWEEP_EN
        req_all = 1'b0; s_req_all = 1'b0;
`endif
        step(); step();

        // reset values
        check("rst_valid",     64'(out_valid), 64'(0));
        check("rst_data",      out_data, 64'(0));
        check("rst_class",     64'(out_class), 64'(0));
        check("rst_frame",     64'(out_frame), 64'(0));
        check("rst_last",      64'(out_last), 64'(0));
        check("rst_err",       64'(err_bad_class), 64'(0));
        check("rst_gen_id",    64'(gen_frame_id), 64'(0));
        check("rst_gen_idx",   64'(gen_frame_index), 64'(0));
        check("rst_busy",      64'(busy), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(1));

        @(negedge clk);
        rst_n = 1'b1;
        step();

        // single class, free-flowing consumer
        do_seq(3'd2, 1'b0, 0);
        check("addr_hold_id",  64'(gen_frame_id), 64'(2));
        check("addr_hold_idx", 64'(gen_frame_index), 64'(2));

        // backpressure on frame 0
        do_seq(3'd5, 1'b0, 1);

        // abort in IDLE drops a simultaneous request
        req_valid = 1'b1; req_class = 3'd1; abort = 1'b1;
        step();
        req_valid = 1'b0; abort = 1'b0;
        check("idle_abort_busy", 64'(busy), 64'(0));
        check("idle_abort_err",  64'(err_bad_class), 64'(0));

        // abort during HOLD of frame 1 with a simultaneous handshake
        req_valid = 1'b1; req_class = 3'd3; out_ready = 1'b1;
        step();
        req_valid = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            if (out_valid && out_frame == 2'd1) found = 1'b1;
            else step();
        end
        check("abort_reach_frame1", 64'(found), 64'(1));
        check("abort_frame_class",  64'(out_class), 64'(3));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_valid",     64'(out_valid), 64'(0));
        check("abort_busy",      64'(busy), 64'(0));
        check("abort_req_ready", 64'(req_ready), 64'(1));
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            if (out_valid) seen++;
            step();
        end
        check("abort_no_frame2", 64'(seen), 64'(0));

        // asynchronous reset during FETCH
        req_valid = 1'b1; req_class = 3'd4;
        step();
        req_valid = 1'b0;
        check("fetch_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("arst_busy",    64'(busy), 64'(0));
        check("arst_valid",   64'(out_valid), 64'(0));
        check("arst_data",    out_data, 64'(0));
        check("arst_gen_id",  64'(gen_frame_id), 64'(0));
        check("arst_gen_idx", 64'(gen_frame_index), 64'(0));
        check("arst_last",    64'(out_last), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        do_seq(3'd4, 1'b0, 0);

        // out-of-range classes on a 6-class instance
        for (int bc = 6; bc < 8; bc++) begin
            s_req_valid = 1'b1; s_req_class = 3'(bc);
            step();
            s_req_valid = 1'b0;
            check("bad_err_pulse", 64'(s_err), 64'(1));
            check("bad_busy",      64'(s_busy), 64'(0));
            check("bad_valid",     64'(s_out_valid), 64'(0));
            step();
            check("bad_err_clear", 64'(s_err), 64'(0));
            check("bad_valid2",    64'(s_out_valid), 64'(0));
        end
        s_req_valid = 1'b1; s_req_class = 3'd5;
        step();
        s_req_valid = 1'b0;
        check("good6_busy", 64'(s_busy), 64'(1));
        check("good6_err",  64'(s_err), 64'(0));
        for (int t = 0; t < 8; t++) step();
        check("good6_done", 64'(s_busy), 64'(0));

        // random classes with random backpressure
        for (int r = 0; r < 4; r++) do_seq(3'($urandom_range(0, 7)), 1'b0, 2);

`ifdef CLASS_SEQ_SWEEP_EN
        do_seq(3'($urandom_range(0, 7)), 1'b1, 0);
        do_seq(3'($urandom_range(0, 7)), 1'b1, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
